// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin snoop-bus arbiter for NUM_CORES L1 caches
//
// Grants the shared snoop bus to one core at a time. Then it broadcasts the
// winner's transaction to every other core, returns the OR of the other
// cores' snoop hits to the winner, and forwards the winner's request to L2.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an owner that keeps requesting is forced to re-arbitrate
//   after MAX_HOLD consecutive grant cycles. When undefined, the owner keeps
//   the bus until its own request falls, and MAX_HOLD has no effect.
//
// Ports:
//   clk                system clock, rising edge
//   reset              synchronous, active-low reset
//   req_core           per-core bus request (level)
//   bus_data_in        per-core bus data, core i at slice i
//   bus_address_in     per-core bus address
//   bus_operation_in   per-core bus operation (2'b00 = no-op)
//   opcode_in          per-core instruction opcode
//   data_to_L2_in      per-core store/writeback data
//   cache_hit_in       per-core snoop hit
//   grant              registered one-hot grant, zero when idle
//   stall              req_core & ~grant
//   bus_data_out       snoop broadcast data (zero on the owner's slice)
//   bus_address_out    snoop broadcast address
//   bus_operation_out  snoop broadcast operation
//   cache_hit_out      aggregated snoop hit, on the owner's bit only
//   address_to_L2      owner address
//   opcode_out         owner opcode
//   data_to_L2_out     owner store data, only for store opcodes

module bus_arbiter_rr #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_HOLD  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req_core,
  input  logic [NUM_CORES*DATA_W-1:0] bus_data_in,
  input  logic [NUM_CORES*ADDR_W-1:0] bus_address_in,
  input  logic [NUM_CORES*2-1:0]      bus_operation_in,
  input  logic [NUM_CORES*7-1:0]      opcode_in,
  input  logic [NUM_CORES*DATA_W-1:0] data_to_L2_in,
  input  logic [NUM_CORES-1:0]        cache_hit_in,
  output logic [NUM_CORES-1:0]        grant,
  output logic [NUM_CORES-1:0]        stall,
  output logic [NUM_CORES*DATA_W-1:0] bus_data_out,
  output logic [NUM_CORES*ADDR_W-1:0] bus_address_out,
  output logic [NUM_CORES*2-1:0]      bus_operation_out,
  output logic [NUM_CORES-1:0]        cache_hit_out,
  output logic [ADDR_W-1:0]           address_to_L2,
  output logic [6:0]                  opcode_out,
  output logic [DATA_W-1:0]           data_to_L2_out
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam logic [6:0] OP_STORE = 7'b0100011;

  if (NUM_CORES < 2 || MAX_HOLD < 2) begin : g_bad_params
    $error("bus_arbiter_rr: NUM_CORES and MAX_HOLD must both be >= 2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] rr_ptr;
  logic             timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt;
  assign timeout = (hold_cnt == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search starting at rr_ptr+1. rr_ptr always equals the
  // current owner while BUSY, so the owner is examined last. This single
  // search therefore serves idle grants, handovers and timeout re-arbitration
  // (a lone requesting owner re-wins).
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!pick_found && req_core[j]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(j);
      end
    end
  end

  logic owner_req;
  assign owner_req = req_core[owner];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= PTR_W'(NUM_CORES - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= BUSY;
            owner    <= pick_idx;
            rr_ptr   <= pick_idx;
            grant    <= NUM_CORES'(1) << pick_idx;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (owner_req && !timeout) begin
`ifdef ARB_TIMEOUT_EN
            if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
`endif
          end else if (pick_found) begin
            // Handover (or timeout re-grant) with no idle bubble.
            owner    <= pick_idx;
            rr_ptr   <= pick_idx;
            grant    <= NUM_CORES'(1) << pick_idx;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Datapath: purely combinational from the registered owner.
  logic              busy;
  logic [DATA_W-1:0] own_data;
  logic [ADDR_W-1:0] own_addr;
  logic [1:0]        own_op;
  logic [6:0]        own_opcode;
  logic [DATA_W-1:0] own_l2;
  logic              hit_others;

  assign busy       = (state == BUSY);
  assign own_data   = bus_data_in[int'(owner)*DATA_W +: DATA_W];
  assign own_addr   = bus_address_in[int'(owner)*ADDR_W +: ADDR_W];
  assign own_op     = bus_operation_in[int'(owner)*2 +: 2];
  assign own_opcode = opcode_in[int'(owner)*7 +: 7];
  assign own_l2     = data_to_L2_in[int'(owner)*DATA_W +: DATA_W];
  assign hit_others = |(cache_hit_in & ~grant);

  always_comb begin
    bus_data_out      = '0;
    bus_address_out   = '0;
    bus_operation_out = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (busy && !grant[i]) begin
        bus_data_out[i*DATA_W +: DATA_W]    = own_data;
        bus_address_out[i*ADDR_W +: ADDR_W] = own_addr;
        bus_operation_out[i*2 +: 2]         = own_op;
      end
    end
  end

  assign cache_hit_out  = busy ? (grant & {NUM_CORES{hit_others}}) : '0;
  assign address_to_L2  = busy ? own_addr : '0;
  assign opcode_out     = busy ? own_opcode : '0;
  assign data_to_L2_out = (busy && own_opcode == OP_STORE) ? own_l2 : '0;
  assign stall          = req_core & ~grant;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - table-driven self-checking bench for bus_arbiter_rr

module tb_bus_arbiter_rr;

  localparam int N = 4;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_core;
  logic [N*32-1:0] bus_data_in, bus_address_in, data_to_L2_in;
  logic [N*2-1:0] bus_operation_in;
  logic [N*7-1:0] opcode_in;
  logic [N-1:0]   cache_hit_in;
  logic [N-1:0]   grant, stall, cache_hit_out;
  logic [N*32-1:0] bus_data_out, bus_address_out;
  logic [N*2-1:0] bus_operation_out;
  logic [31:0]    address_to_L2, data_to_L2_out;
  logic [6:0]     opcode_out;

  bus_arbiter_rr #(.NUM_CORES(N), .DATA_W(32), .ADDR_W(32), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req_core(req_core),
    .bus_data_in(bus_data_in), .bus_address_in(bus_address_in),
    .bus_operation_in(bus_operation_in), .opcode_in(opcode_in),
    .data_to_L2_in(data_to_L2_in), .cache_hit_in(cache_hit_in),
    .grant(grant), .stall(stall), .bus_data_out(bus_data_out),
    .bus_address_out(bus_address_out), .bus_operation_out(bus_operation_out),
    .cache_hit_out(cache_hit_out), .address_to_L2(address_to_L2),
    .opcode_out(opcode_out), .data_to_L2_out(data_to_L2_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] addr_c [N];
  logic [31:0] bdat_c [N];
  logic [31:0] l2_c   [N];
  logic [1:0]  op_c   [N];
  logic [6:0]  opc_c  [N];

  typedef struct {
    logic [3:0] req;
    logic [3:0] hit;
    logic [3:0] g;
    logic [3:0] s;
    logic [3:0] h;
  } vec_t;

  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected datapath is derived from the expected grant and the bench's own
  // per-core constants.
  task automatic check_all(input string tag, input logic [3:0] eg,
                           input logic [3:0] es, input logic [3:0] eh);
    int o;
    logic v;
    logic [127:0] ea, ed;
    logic [7:0] eop;
    o = 0;
    v = |eg;
    for (int i = 0; i < N; i++) if (eg[i]) o = i;
    ea = '0; ed = '0; eop = '0;
    for (int i = 0; i < N; i++) begin
      if (v && !eg[i]) begin
        ea[i*32 +: 32] = addr_c[o];
        ed[i*32 +: 32] = bdat_c[o];
        eop[i*2 +: 2]  = op_c[o];
      end
    end
    check({tag, " grant"}, 128'(grant), 128'(eg));
    check({tag, " stall"}, 128'(stall), 128'(es));
    check({tag, " cache_hit_out"}, 128'(cache_hit_out), 128'(eh));
    check({tag, " bus_address_out"}, bus_address_out, ea);
    check({tag, " bus_data_out"}, bus_data_out, ed);
    check({tag, " bus_operation_out"}, 128'(bus_operation_out), 128'(eop));
    check({tag, " address_to_L2"}, 128'(address_to_L2), 128'(v ? addr_c[o] : 32'h0));
    check({tag, " opcode_out"}, 128'(opcode_out), 128'(v ? opc_c[o] : 7'h0));
    check({tag, " data_to_L2_out"}, 128'(data_to_L2_out),
          128'((v && opc_c[o] == OP_STORE) ? l2_c[o] : 32'h0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_core = '0;
    cache_hit_in = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_c[i] = 32'h0000_1000 + 32'(i) * 32'h40;
      bdat_c[i] = 32'hB0B0_0000 + 32'(i);
      op_c[i]   = 2'(i);
    end
    opc_c[0] = OP_STORE;     l2_c[0] = 32'h0000_AAAA;
    opc_c[1] = OP_STORE;     l2_c[1] = 32'hDEAD_BEEF;
    opc_c[2] = OP_LOAD;      l2_c[2] = 32'h2222_2222;
    opc_c[3] = 7'b0110011;   l2_c[3] = 32'h3333_3333;
    for (int i = 0; i < N; i++) begin
      bus_address_in[i*32 +: 32] = addr_c[i];
      bus_data_in[i*32 +: 32]    = bdat_c[i];
      data_to_L2_in[i*32 +: 32]  = l2_c[i];
      bus_operation_in[i*2 +: 2] = op_c[i];
      opcode_in[i*7 +: 7]        = opc_c[i];
    end

    //            req      hit      grant    stall    hit_out
    tbl[0] = '{4'b0101, 4'b0000, 4'b0001, 4'b0100, 4'b0000};
    tbl[1] = '{4'b0100, 4'b0001, 4'b0100, 4'b0000, 4'b0100};
    tbl[2] = '{4'b0110, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    tbl[3] = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0010};
    tbl[4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[6] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    tbl[7] = '{4'b1001, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
    tbl[8] = '{4'b0001, 4'b0110, 4'b0001, 4'b0000, 4'b0001};

    reset = 1'b0;
    req_core = '0;
    cache_hit_in = '0;
    tick();
    check_all("in_reset", 4'b0000, 4'b0000, 4'b0000);
    tick();
    reset = 1'b1;
    tick();
    check_all("post_reset", 4'b0000, 4'b0000, 4'b0000);

    for (int r = 0; r < 9; r++) begin
      req_core = tbl[r].req;
      cache_hit_in = tbl[r].hit;
      tick();
      check_all($sformatf("vec%0d", r), tbl[r].g, tbl[r].s, tbl[r].h);
    end

    // All four requesting; each owner drops for its single granted cycle.
    do_reset();
    req_core = 4'b1111;
    tick();
    check_all("rr0", 4'b0001, 4'b1110, 4'b0000);
    req_core = 4'b1110;
    tick();
    check_all("rr1", 4'b0010, 4'b1100, 4'b0000);
    req_core = 4'b1101;
    tick();
    check_all("rr2", 4'b0100, 4'b1001, 4'b0000);
    req_core = 4'b1011;
    tick();
    check_all("rr3", 4'b1000, 4'b0011, 4'b0000);
    req_core = 4'b0111;
    tick();
    check_all("rr4", 4'b0001, 4'b0110, 4'b0000);

    // Two requesters held: hold limit behaviour.
    do_reset();
    req_core = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hold_c%0d grant", c), 128'(grant), 128'(4'b0001));
    end
    tick();
    check("hold_handover grant", 128'(grant), 128'(4'b0010));
`else
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("hold_c%0d grant", c), 128'(grant), 128'(4'b0001));
    end
`endif

    // Lone requester keeps (or is re-granted) the bus with no gap.
    do_reset();
    req_core = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("solo_c%0d grant", c), 128'(grant), 128'(4'b0001));
    end

    // Reset mid-transaction, then the pointer favours lower indices.
    do_reset();
    req_core = 4'b0100;
    tick();
    check_all("mid_pre", 4'b0100, 4'b0000, 4'b0000);
    reset = 1'b0;
    tick();
    check_all("mid_reset", 4'b0000, 4'b0100, 4'b0000);
    reset = 1'b1;
    req_core = 4'b1100;
    tick();
    check_all("mid_post", 4'b0100, 4'b1000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
